// File: rtl/wgt_buf_pkg.sv
// Shared types and default widths for the double-buffered weight bank.
package wgt_buf_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 8;

  typedef logic [0:0] bank_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/wgt_buf_ram.sv
// Simple dual-port RAM holding both weight banks; the bank index is the address MSB.
// One write port, one read port with a single-cycle registered read.
module wgt_buf_ram
  import wgt_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** (ADDR_W + 1);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/wgt_bank_buf.sv
// Double-buffered weight bank: img2col writes fill one bank while the other streams to the PE array.
// Optional macro WGT_BUF_ERR_CHK_EN enables write/load acceptance checks and the sticky wr_err flag.
module wgt_bank_buf
  import wgt_buf_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wgt_wr_en,
  input  logic [ADDR_W-1:0] wgt_wr_addr,
  input  logic [DATA_W-1:0] wgt_wr_data,
  input  logic              chn_sel,
  input  logic              load_done,
  input  logic [ADDR_W-1:0] load_last_addr,
  input  logic              feed_start,
  input  logic              feed_ready,
  output logic              feed_valid,
  output logic [DATA_W-1:0] feed_data,
  output logic              feed_last,
  output logic [1:0]        bank_full,
  output logic              busy,
  output logic              wr_err
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  state_t            state, state_nxt;
  bank_idx_t         rd_bank;
  logic [ADDR_W-1:0] rd_addr, cur_last;
  logic [LEN_W-1:0]  len_q [2];
  logic              rd_vld_q, rd_last_q;
  logic [DATA_W-1:0] ram_rdata;

  // Two-entry output FIFO: head drives the stream outputs, tail holds the next word
  logic              h_vld, h_last, t_vld, t_last;
  logic [DATA_W-1:0] h_data, t_data;

  logic       pop, issue, honour, drain_done, wr_ok, ld_ok;
  logic [1:0] occ_after;

  assign pop        = h_vld & feed_ready;
  assign feed_valid = h_vld;
  assign feed_data  = h_data;
  assign feed_last  = h_last;

`ifdef WGT_BUF_ERR_CHK_EN
  logic wr_bank_busy;
  assign wr_bank_busy = (state != IDLE) && (rd_bank == chn_sel);
  assign wr_ok = wgt_wr_en && !bank_full[chn_sel] && !wr_bank_busy;
  assign ld_ok = load_done && !bank_full[chn_sel] && !(drain_done && (rd_bank == chn_sel));

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else if ((wgt_wr_en && !wr_ok) || (load_done && !ld_ok)) begin
      wr_err <= 1'b1;
    end
  end
`else
  assign wr_ok  = wgt_wr_en;
  assign ld_ok  = load_done;
  assign wr_err = 1'b0;
`endif

  wgt_buf_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (wr_ok),
    .waddr ({chn_sel, wgt_wr_addr}),
    .wdata (wgt_wr_data),
    .re    (issue),
    .raddr ({rd_bank, rd_addr}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Reads are issued only if the FIFO can absorb them after this cycle's pop
  always_comb begin
    state_nxt  = state;
    honour     = 1'b0;
    issue      = 1'b0;
    drain_done = 1'b0;
    occ_after  = {1'b0, h_vld} + {1'b0, t_vld} + {1'b0, rd_vld_q} - {1'b0, pop};
    case (state)
      IDLE: begin
        if (feed_start && bank_full[rd_bank]) begin
          honour    = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (occ_after < 2'd2) begin
          issue = 1'b1;
          if (rd_addr == cur_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && h_last) begin
          drain_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      rd_bank   <= '0;
      rd_addr   <= '0;
      cur_last  <= '0;
      bank_full <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      busy      <= 1'b0;
      h_vld     <= 1'b0;
      h_last    <= 1'b0;
      h_data    <= '0;
      t_vld     <= 1'b0;
      t_last    <= 1'b0;
      t_data    <= '0;
    end else begin
      rd_vld_q  <= issue;
      rd_last_q <= issue && (rd_addr == cur_last);
      busy      <= (state_nxt != IDLE);

      // Stream length is latched at start so later loads cannot truncate it
      if (honour) begin
        rd_addr  <= '0;
        cur_last <= ADDR_W'(len_q[rd_bank] - LEN_W'(1));
      end else if (issue) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end

      if (ld_ok) begin
        bank_full[chn_sel] <= 1'b1;
        len_q[chn_sel]     <= LEN_W'(load_last_addr) + LEN_W'(1);
      end
      if (drain_done) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end

      if (pop) begin
        if (t_vld) begin
          h_data <= t_data;
          h_last <= t_last;
          if (rd_vld_q) begin
            t_data <= ram_rdata;
            t_last <= rd_last_q;
          end else begin
            t_vld  <= 1'b0;
            t_last <= 1'b0;
          end
        end else if (rd_vld_q) begin
          h_data <= ram_rdata;
          h_last <= rd_last_q;
        end else begin
          h_vld  <= 1'b0;
          h_last <= 1'b0;
        end
      end else if (rd_vld_q) begin
        if (!h_vld) begin
          h_vld  <= 1'b1;
          h_data <= ram_rdata;
          h_last <= rd_last_q;
        end else begin
          t_vld  <= 1'b1;
          t_data <= ram_rdata;
          t_last <= rd_last_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_wgt_bank_buf.sv
// Self-checking bench for wgt_bank_buf: cycle vector table, directed stream sequences and
// randomized ping-pong traffic against a bank-content reference model.
module tb_wgt_bank_buf;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

`ifdef WGT_BUF_ERR_CHK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          wgt_wr_en = 1'b0;
  logic [AW-1:0] wgt_wr_addr = '0;
  logic [DW-1:0] wgt_wr_data = '0;
  logic          chn_sel = 1'b0;
  logic          load_done = 1'b0;
  logic [AW-1:0] load_last_addr = '0;
  logic          feed_start = 1'b0;
  logic          feed_ready = 1'b1;
  logic          feed_valid;
  logic [DW-1:0] feed_data;
  logic          feed_last;
  logic [1:0]    bank_full;
  logic          busy;
  logic          wr_err;

  wgt_bank_buf #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock          (clock),
    .rst            (rst),
    .wgt_wr_en      (wgt_wr_en),
    .wgt_wr_addr    (wgt_wr_addr),
    .wgt_wr_data    (wgt_wr_data),
    .chn_sel        (chn_sel),
    .load_done      (load_done),
    .load_last_addr (load_last_addr),
    .feed_start     (feed_start),
    .feed_ready     (feed_ready),
    .feed_valid     (feed_valid),
    .feed_data      (feed_data),
    .feed_last      (feed_last),
    .bank_full      (bank_full),
    .busy           (busy),
    .wr_err         (wr_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic        ch;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        ld;
    logic [7:0]  last;
    logic        st;
    logic [1:0]  e_bf;
    logic        e_busy;
    logic        e_vld;
    logic [15:0] e_data;
    logic        e_last;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        last;
    int          cyc;
  } word_t;

  vec_t  tbl [17];
  word_t got[$];
  word_t exp_q[$];

  // Reference model: bank contents, lengths and flags at transaction level
  logic [15:0] mem_m [2][256];
  bit          full_m [2];
  int          len_m [2];
  bit          rd_m, strm_m, err_m;

  int          checks, errors, cyc, busy_cnt, ready_mode;
  bit          stall_prev;
  logic [15:0] stall_data;
  logic        stall_last;

  function automatic vec_t v(input logic wr, input logic ch, input logic [7:0] addr,
                             input logic [15:0] data, input logic ld, input logic [7:0] last,
                             input logic st, input logic [1:0] bf, input logic bsy,
                             input logic vld, input logic [15:0] ed, input logic el,
                             input logic er);
    vec_t r;
    r.wr = wr; r.ch = ch; r.addr = addr; r.data = data; r.ld = ld; r.last = last; r.st = st;
    r.e_bf = bf; r.e_busy = bsy; r.e_vld = vld; r.e_data = ed; r.e_last = el; r.e_err = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then advance past the rising edge
  task automatic step();
    @(negedge clock);
    cyc++;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (stall_prev) begin
        checks++;
        if (!(feed_valid === 1'b1 && feed_data === stall_data && feed_last === stall_last)) begin
          errors++;
          $display("FAIL stall_hold actual v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                   feed_valid, feed_data, feed_last, stall_data, stall_last);
        end
      end
      if (feed_valid && feed_ready) begin
        word_t w;
        w.data = feed_data;
        w.last = feed_last;
        w.cyc  = cyc;
        got.push_back(w);
      end
      stall_prev = feed_valid && !feed_ready;
      stall_data = feed_data;
      stall_last = feed_last;
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clock);
    #1;
    case (ready_mode)
      1:       feed_ready = ~feed_ready;
      2:       feed_ready = ($urandom_range(3, 0) != 0);
      default: feed_ready = 1'b1;
    endcase
  endtask

  task automatic drive(input logic wr, input logic ch, input logic [7:0] a, input logic [15:0] d,
                       input logic ld, input logic [7:0] last, input logic st);
    wgt_wr_en = wr; chn_sel = ch; wgt_wr_addr = a; wgt_wr_data = d;
    load_done = ld; load_last_addr = last; feed_start = st;
    step();
    wgt_wr_en = 1'b0; load_done = 1'b0; feed_start = 1'b0;
  endtask

  task automatic op(input logic wr, input logic ch, input logic [7:0] a, input logic [15:0] d,
                    input logic ld, input logic [7:0] last, input logic st);
    bit ok;
    if (wr) begin
      ok = !ERR_CHK || (!full_m[ch] && !(strm_m && rd_m == ch));
      if (ok) mem_m[ch][a] = d;
      else    err_m = 1'b1;
    end
    if (ld) begin
      ok = !ERR_CHK || !full_m[ch];
      if (ok) begin
        full_m[ch] = 1'b1;
        len_m[ch]  = int'(last) + 1;
      end else begin
        err_m = 1'b1;
      end
    end
    if (st && !strm_m && full_m[rd_m]) begin
      strm_m = 1'b1;
      for (int i = 0; i < len_m[rd_m]; i++) begin
        word_t w;
        w.data = mem_m[rd_m][i];
        w.last = (i == len_m[rd_m] - 1);
        w.cyc  = 0;
        exp_q.push_back(w);
      end
    end
    drive(wr, ch, a, d, ld, last, st);
  endtask

  // Final word of the fill carries load_done in the same cycle
  task automatic fill(input logic ch, input int n, input int base, input bit rnd);
    for (int a = 0; a < n; a++) begin
      logic [15:0] d;
      d = rnd ? 16'($urandom) : 16'(base + a);
      op(1'b1, ch, 8'(a), d, (a == n - 1), 8'(n - 1), 1'b0);
    end
  endtask

  task automatic start();
    op(1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
    if (!busy && strm_m) begin
      full_m[rd_m] = 1'b0;
      rd_m   = ~rd_m;
      strm_m = 1'b0;
    end
  endtask

  task automatic wait_words(input int n, input string name);
    int k = 0;
    while (got.size() < n && k < 1000) begin
      step();
      k++;
    end
    chk({name, "_words_seen"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic compare_stream(input string name);
    chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].data !== exp_q[i].data || got[i].last !== exp_q[i].last) begin
        errors++;
        $display("FAIL %s word %0d actual d=%0h last=%0b required d=%0h last=%0b",
                 name, i, got[i].data, got[i].last, exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic clear_q();
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wgt_wr_en = 1'b0; load_done = 1'b0; feed_start = 1'b0;
    step();
    step();
    chk("reset_valid", 32'(feed_valid), 32'd0);
    chk("reset_bank_full", 32'(bank_full), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err", 32'(wr_err), 32'd0);
    chk("reset_last", 32'(feed_last), 32'd0);
    rst = 1'b0;
    full_m[0] = 1'b0; full_m[1] = 1'b0;
    len_m[0] = 0; len_m[1] = 0;
    rd_m = 1'b0; strm_m = 1'b0; err_m = 1'b0;
    stall_prev = 1'b0;
    clear_q();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; busy_cnt = 0; ready_mode = 0;

    // Cycle table: wr ch addr data ld last st | bank_full busy valid data last err(if checking)
    tbl[0]  = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b00,1'b0,1'b0,16'h0000,1'b0,1'b0);
    tbl[1]  = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b1, 2'b00,1'b0,1'b0,16'h0000,1'b0,1'b0);
    tbl[2]  = v(1'b1,1'b1,8'h00,16'h0055,1'b0,8'h00,1'b0, 2'b00,1'b0,1'b0,16'h0000,1'b0,1'b0);
    tbl[3]  = v(1'b0,1'b1,8'h00,16'h0000,1'b1,8'h00,1'b0, 2'b10,1'b0,1'b0,16'h0000,1'b0,1'b0);
    tbl[4]  = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b1, 2'b10,1'b0,1'b0,16'h0000,1'b0,1'b0);
    tbl[5]  = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b10,1'b0,1'b0,16'h0000,1'b0,1'b0);
    tbl[6]  = v(1'b0,1'b1,8'h00,16'h0000,1'b1,8'h00,1'b0, 2'b10,1'b0,1'b0,16'h0000,1'b0,1'b1);
    tbl[7]  = v(1'b1,1'b1,8'h01,16'h0077,1'b0,8'h00,1'b0, 2'b10,1'b0,1'b0,16'h0000,1'b0,1'b1);
    tbl[8]  = v(1'b1,1'b0,8'h00,16'h00AA,1'b1,8'h00,1'b0, 2'b11,1'b0,1'b0,16'h0000,1'b0,1'b1);
    tbl[9]  = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b1, 2'b11,1'b1,1'b0,16'h0000,1'b0,1'b1);
    tbl[10] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b11,1'b1,1'b0,16'h0000,1'b0,1'b1);
    tbl[11] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b11,1'b1,1'b1,16'h00AA,1'b1,1'b1);
    tbl[12] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b10,1'b0,1'b0,16'h0000,1'b0,1'b1);
    tbl[13] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b1, 2'b10,1'b1,1'b0,16'h0000,1'b0,1'b1);
    tbl[14] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b10,1'b1,1'b0,16'h0000,1'b0,1'b1);
    tbl[15] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b10,1'b1,1'b1,16'h0055,1'b1,1'b1);
    tbl[16] = v(1'b0,1'b0,8'h00,16'h0000,1'b0,8'h00,1'b0, 2'b00,1'b0,1'b0,16'h0000,1'b0,1'b1);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].wr, tbl[i].ch, tbl[i].addr, tbl[i].data, tbl[i].ld, tbl[i].last, tbl[i].st);
      chk($sformatf("vec%0d_bank_full", i), 32'(bank_full), 32'(tbl[i].e_bf));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_valid", i), 32'(feed_valid), 32'(tbl[i].e_vld));
      chk($sformatf("vec%0d_err", i), 32'(wr_err), 32'(tbl[i].e_err & ERR_CHK));
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d_data", i), 32'(feed_data), 32'(tbl[i].e_data));
        chk($sformatf("vec%0d_last", i), 32'(feed_last), 32'(tbl[i].e_last));
      end
    end

    // 108-word bank at full rate
    do_reset();
    fill(1'b0, 108, 0, 1'b0);
    busy_cnt = 0;
    start();
    wait_idle(400, "full_rate");
    compare_stream("full_rate");
    chk("full_rate_busy_cycles", 32'(busy_cnt), 32'd110);
    if (got.size() >= 108) chk("full_rate_no_bubble", 32'(got[107].cyc - got[0].cyc), 32'd107);
    chk("full_rate_bank_full", 32'(bank_full), 32'd0);
    clear_q();

    // Same bank under alternating backpressure
    do_reset();
    fill(1'b0, 108, 0, 1'b0);
    ready_mode = 1;
    start();
    wait_idle(600, "toggle_ready");
    compare_stream("toggle_ready");
    ready_mode = 0;
    clear_q();

    // Ping-pong fill of bank 1 during bank 0 stream, plus illegal write to the streaming bank
    do_reset();
    fill(1'b0, 108, 0, 1'b0);
    start();
    fill(1'b1, 36, 16'h100, 1'b0);
    chk("pingpong_err", 32'(wr_err), 32'(err_m));
    start();
    chk("busy_start_ignored_bf", 32'(bank_full), 32'd3);
    wait_words(20, "pingpong");
    op(1'b1, 1'b0, 8'h00, 16'hDEAD, 1'b0, 8'h00, 1'b0);
    chk("stream_bank_write_err", 32'(wr_err), 32'(ERR_CHK));
    chk("stream_bank_write_model", 32'(wr_err), 32'(err_m));
    wait_idle(400, "pingpong_b0");
    compare_stream("pingpong_b0");
    clear_q();
    start();
    wait_idle(200, "pingpong_b1");
    compare_stream("pingpong_b1");
    chk("pingpong_bank_full", 32'(bank_full), 32'd0);
    clear_q();

    // Reset in the middle of a stream, then a fresh stream from word 0
    do_reset();
    fill(1'b0, 108, 0, 1'b0);
    start();
    wait_words(50, "midreset");
    rst = 1'b1;
    step();
    chk("midreset_valid", 32'(feed_valid), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_bank_full", 32'(bank_full), 32'd0);
    rst = 1'b0;
    full_m[0] = 1'b0; full_m[1] = 1'b0;
    rd_m = 1'b0; strm_m = 1'b0; err_m = 1'b0;
    clear_q();
    fill(1'b0, 20, 16'h5A00, 1'b0);
    start();
    wait_idle(200, "after_reset");
    compare_stream("after_reset");
    clear_q();

    // Randomized ping-pong with random backpressure and a full-depth bank
    do_reset();
    ready_mode = 2;
    fill(1'b0, int'($urandom_range(64, 1)), 0, 1'b1);
    for (int r = 0; r < 10; r++) begin
      int l;
      l = (r == 3) ? 256 : int'($urandom_range(64, 1));
      start();
      fill(~rd_m, l, 0, 1'b1);
      wait_idle(2000, $sformatf("rand%0d", r));
      compare_stream($sformatf("rand%0d", r));
      clear_q();
    end
    start();
    wait_idle(2000, "rand_final");
    compare_stream("rand_final");
    clear_q();
    chk("rand_bank_full", 32'(bank_full), 32'd0);
    chk("rand_err", 32'(wr_err), 32'(err_m));
    ready_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wgt_bank_buf.md
# wgt_bank_buf

Double-buffered weight bank that receives the column-ordered weight stream written by the img2col weight stage (`wgt_wr_en`/`wgt_wr_addr`/`wgt_out`/`chn_sel`). It stores each stream in one of two banks selected by `chn_sel`, then reads a completed bank back out to the PE array over a valid/ready stream. While one bank is being consumed, the other bank can be filled, so weight reorganisation overlaps compute.

## Interface
- `DATA_W`, 16, weight word width
- `ADDR_W`, 8, per-bank address width; bank depth = 2**ADDR_W
- `clock`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `wgt_wr_en`  in  1  write strobe from img2col weight stage
- `wgt_wr_addr`  in  ADDR_W  write address within bank
- `wgt_wr_data`  in  DATA_W  write data (img2col `wgt_out`)
- `chn_sel`  in  1  target bank for writes and `load_done`
- `load_done`  in  1  one-cycle pulse: bank `chn_sel` complete
- `load_last_addr`  in  ADDR_W  last written address; sampled with `load_done`
- `feed_start`  in  1  one-cycle pulse: stream the next full bank
- `feed_ready`  in  1  PE array accepts `feed_data`
- `feed_valid`  out  1  `feed_data` valid
- `feed_data`  out  DATA_W  weight word, address order 0..len-1
- `feed_last`  out  1  qualifies the final word of the bank
- `bank_full`  out  2  per-bank full flags
- `busy`  out  1  stream in progress
- `wr_err`  out  1  sticky protocol-violation flag

## Operation
- Reset values: all outputs 0. `rd_bank`=0, FSM=IDLE, output FIFO empty, stored lengths 0.
- Write path:
  - A write is accepted when `wgt_wr_en`=1, bank `chn_sel` is not full, and that bank is not being streamed.
  - Otherwise the write is dropped and `wr_err` is set.
- Load completion:
  - `load_done` on a non-full bank sets `bank_full[chn_sel]` and stores len = `load_last_addr`+1, ADDR_W+1 bits, range 1..2**ADDR_W.
  - `load_done` on a full bank is ignored and sets `wr_err`.
- Read bank selection:
  - `rd_bank` alternates 0,1,0,… strictly; it does not skip banks.
  - `feed_start` is honoured only in IDLE with `bank_full[rd_bank]`=1. Otherwise it is ignored and no error is raised.
- FSM:
  - IDLE: on an honoured `feed_start` → STREAM. Clear rd_addr and set `busy`=1.
  - STREAM: issue a RAM read of rd_addr whenever FIFO occupancy + in-flight reads < 2. Increment rd_addr per issued read. After issuing address len-1 → DRAIN.
  - DRAIN: wait for the FIFO to empty, i.e. the `feed_last` handshake completes. Then clear `bank_full[rd_bank]`, toggle `rd_bank`, set `busy`=0, and return to IDLE.
- Output: a 2-entry FIFO; `feed_valid` = FIFO not empty. The word pops when `feed_valid`&&`feed_ready`. `feed_last` is 1 on the word read from address len-1.
- Simultaneous events:
  - A write and `load_done` in the same cycle on the same bank: the write lands first, then the bank is marked full.
  - Stream completion clearing bank b in the same cycle as `load_done` on bank b: the clear wins, and `load_done` sets `wr_err`.
- Reset mid-stream: the cycle after `rst`, `feed_valid`=0 and `bank_full`=00. Any partial stream is discarded and RAM contents are undefined-but-ignored.

## Timing
- RAM read latency is 1 cycle.
- An honoured `feed_start` at edge T gives STREAM at T+1, first read issued at T+1, and `feed_valid`=1 after T+2.
- With `feed_ready` held at 1: one word per cycle, no bubbles. A bank of len words takes len+2 cycles from `feed_start` to IDLE.
- Backpressure: `feed_data` and `feed_last` hold stable while `feed_valid`&&!`feed_ready`. Words are never dropped or duplicated.
- A write accepted at edge T is readable by a stream starting at T+1.

## Configuration
- `WGT_BUF_ERR_CHK_EN` defined: acceptance checks and `wr_err` behave as described above.
- Not defined: every write and every `load_done` is accepted unconditionally, including on a full or streaming bank, and `wr_err` is tied to 0. Stream ordering and FSM are unchanged.

## Structure
- Package `wgt_buf_pkg` holds:
  - FSM state enum {IDLE, STREAM, DRAIN}
  - default `DATA_W`/`ADDR_W` localparams
  - bank-index typedef
- One sub-module, `wgt_buf_ram`: simple dual-port RAM of 2·2**ADDR_W × DATA_W. Bank bit is the address MSB; 1-cycle registered read.
- The FIFO and FSM stay in the top level.

## Test plan
- Fill bank 0 with addr 0..107, data=addr; `load_done` with last=107; `feed_start` with `feed_ready`=1 → 108 consecutive words 0..107, `feed_last` on 107, `bank_full`=00 afterwards, `busy` high for 110 cycles.
- Same fill, `feed_ready` toggling 1,0,1,0 → identical sequence 0..107 with no drop or duplicate; data stable while stalled.
- Ping-pong: stream bank 0 while writing bank 1 with data 0x100+addr (len 36) → `wr_err`=0; second `feed_start` yields 0x100..0x123.
- With `WGT_BUF_ERR_CHK_EN`: write bank 0 during its stream → `wr_err`=1 and the stream is unaltered. Without the macro, `wr_err` stays 0.
- `feed_start` with `bank_full`=00, or with only bank 1 full while `rd_bank`=0 → ignored, `feed_valid` stays 0.
- Assert `rst` after the 50th word → next cycle `feed_valid`=0, `busy`=0, `bank_full`=00; a fresh load/feed then works from word 0.
